// File: rtl/if_id_queue_if.sv
// IF -> ID instruction queue bus: fetch side, backpressure, and head-of-queue outputs.
interface if_id_queue_if #(
    parameter int unsigned CNT_W = 3
);
    logic [31:0]      PC_if;
    logic [31:0]      Instruction_if;
    logic             IF_flush;
    logic             IFWrite;
    logic             ID_ready;
    logic             Valid_id;
    logic [31:0]      PC_id;
    logic [31:0]      Instruction_id;
    logic [CNT_W-1:0] Count;

    modport master (
        output PC_if, Instruction_if, IF_flush, ID_ready,
        input  IFWrite, Valid_id, PC_id, Instruction_id, Count
    );

    modport slave (
        input  PC_if, Instruction_if, IF_flush, ID_ready,
        output IFWrite, Valid_id, PC_id, Instruction_id, Count
    );
endinterface

// File: rtl/if_id_queue.sv
// Decoupling instruction queue between IF and ID: circular buffer of {PC, instruction}
// with registered-state backpressure (IFWrite) and whole-queue flush on IF_flush.
module if_id_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2,
    parameter int unsigned CNT_W = 3
) (
    input  logic          clk,
    input  logic          reset,
    if_id_queue_if.slave  q
);
    logic [31:0]      r_pc_mem    [DEPTH];
    logic [31:0]      r_instr_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    // Flush wins over both sides; a pop while full never frees a slot in the same cycle.
    assign w_push  = ~w_full & ~q.IF_flush;
    assign w_pop   = ~w_empty & q.ID_ready & ~q.IF_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (q.IF_flush) begin
            r_count  <= '0;
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_pc_mem[r_wr_ptr]    <= q.PC_if;
            r_instr_mem[r_wr_ptr] <= q.Instruction_if;
        end
    end

    assign q.IFWrite        = ~w_full;
    assign q.Valid_id       = ~w_empty;
    assign q.PC_id          = w_empty ? 32'h0 : r_pc_mem[r_rd_ptr];
    assign q.Instruction_id = w_empty ? 32'h0 : r_instr_mem[r_rd_ptr];
    assign q.Count          = r_count;
endmodule
